stream_driver: RTL
==================

STREAM_DRIVER -- requirements
Module: stream_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 40, finish-wait watchdog limit in clk cycles.
REQ-002 SHALL have parameter DW, default 8, width of data_A/data_B/result.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 launch  in  1  one-cycle pulse, begins a round; ignored unless IDLE.
REQ-006 cfg_count  in  8  beats in round, sampled on launch.
REQ-007 cfg_gap  in  1  insert one idle cycle after every beat, sampled on launch.
REQ-008 exp_value  in  DW  golden result, sampled on launch.
REQ-009 rec_valid / rec_ready  in / out  1 / 1  record-source handshake; transfer when both high.
REQ-010 rec_a, rec_b  in  DW  operand record; rec_instr  in  4  instruction record.
REQ-011 start  out  1; count  out  8; valid  out  1; data_A, data_B  out  DW; instruction  out  4  drive side of the compute protocol.
REQ-012 finish  in  1; third_largest  in  DW  response side of the compute protocol.
REQ-013 busy  out  1; done  out  1  (one-cycle pulse); pass  out  1; result  out  DW; err_cnt  out  8; timeout  out  1; proto_err  out  1.

Function
REQ-014 FSM states SHALL be IDLE, START, SEND, GAP, WAIT, CHECK.
REQ-015 IDLE + launch -> START; START lasts exactly one cycle, start=1, count=latched cfg_count; count SHALL be 0 in all other states.
REQ-016 START -> SEND if count>0, else -> WAIT.
REQ-017 SEND: rec_ready=1; on transfer drive valid=1 with rec_a/rec_b/rec_instr in that cycle, decrement beat counter; no transfer -> valid=0, stall.
REQ-018 After each beat: gap latched -> GAP (one cycle, valid=0) -> SEND; last beat -> WAIT (via GAP if gap latched).
REQ-019 rec_ready SHALL be 0 outside SEND; data_A/data_B/instruction SHALL be 0 whenever valid=0.
REQ-020 WAIT: finish=1 -> capture third_largest into result -> CHECK.
REQ-021 CHECK (one cycle): done=1, pass=(result==exp_value); mismatch increments err_cnt (saturating at 255); -> IDLE.
REQ-022 finish high on two consecutive cycles, or high in START/SEND/GAP, SHALL set proto_err (sticky) and increment err_cnt; the early finish is otherwise ignored.
REQ-023 busy=1 in every state except IDLE; launch while busy SHALL be ignored.
REQ-024 pass and result SHALL hold until next CHECK.

Reset
REQ-025 rst SHALL return FSM to IDLE in the next cycle from any state, including mid-SEND/WAIT, abandoning the round without done.
REQ-026 Reset values: start=0, count=0, valid=0, data_A=0, data_B=0, instruction=0, rec_ready=0, busy=0, done=0, pass=0, result=0, err_cnt=0, timeout=0, proto_err=0.

Configuration
REQ-027 With STREAM_DRV_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYC without finish SHALL set timeout (sticky until rst), increment err_cnt, pulse done with pass=0, -> IDLE.
REQ-028 Without STREAM_DRV_TIMEOUT_EN: no watchdog counter exists; WAIT persists until finish or rst; timeout tied 0.

Structure
REQ-029 Shared package SHALL hold the state enum, the 4-bit instruction type, and the TIMEOUT_CYC default.
REQ-030 Beat/idle counter plus watchdog SHALL be one sub-module, drv_counter; everything else in stream_driver.

Verification
REQ-031 cfg_count=3, gap=0, records (10,20,1),(30,40,2),(50,60,3) always valid -> start 1 cycle with count=3, valid high 3 consecutive cycles with those values.
REQ-032 cfg_count=2, gap=1 -> valid pattern 1,0,1,0 then WAIT; finish with third_largest=0x2A, exp_value=0x2A -> done pulse, pass=1, err_cnt=0.
REQ-033 rec_valid low 2 cycles mid-round -> valid low 2 cycles, no beat lost, count of valid pulses equals cfg_count.
REQ-034 exp_value=5, third_largest=7 -> pass=0, err_cnt=1; finish held 2 cycles -> proto_err=1, err_cnt=2.
REQ-035 STREAM_DRV_TIMEOUT_EN defined, finish never asserts -> after 40 WAIT cycles timeout=1, done pulse, pass=0, FSM IDLE.
REQ-036 rst asserted mid-SEND -> next cycle all outputs at reset values; subsequent launch runs a normal round.

Source files
------------

// File: rtl/stream_driver_pkg.sv
// Shared types and defaults for the stream_driver block and its beat/watchdog counter.
package stream_driver_pkg;

  typedef enum logic [2:0] {IDLE, START, SEND, GAP, WAIT, CHECK} state_t;

  typedef logic [3:0] instr_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 40;

  // 8-bit saturating increment, used for the error counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/drv_counter.sv
// Beat counter for a stream_driver round plus the optional finish-wait watchdog.
// Watchdog is present only when STREAM_DRV_TIMEOUT_EN is defined.
module drv_counter
  import stream_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] beats,
  output logic       last,
  input  logic       wd_run,
  output logic       wd_expired
);

  always_ff @(posedge clk) begin
    if (rst) begin
      beats <= '0;
    end else if (load) begin
      beats <= load_val;
    end else if (dec && (beats != '0)) begin
      beats <= beats - 8'd1;
    end
  end

  assign last = (beats == 8'd1);

`ifdef STREAM_DRV_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd;

  // Cleared whenever the driver leaves WAIT, so each round starts from zero
  always_ff @(posedge clk) begin
    if (rst || !wd_run) begin
      wd <= '0;
    end else if (!wd_expired) begin
      wd <= wd + 1'b1;
    end
  end

  assign wd_expired = wd_run && (wd == WDW'(TIMEOUT_CYC - 1));
`else
  logic unused_wd;
  assign unused_wd  = wd_run & (TIMEOUT_CYC != 0);
  assign wd_expired = 1'b0;
`endif

endmodule

// File: rtl/stream_driver.sv
// Drives one round of operand records into the compute protocol and checks its result.
// Optional finish-wait watchdog enabled by defining STREAM_DRV_TIMEOUT_EN.
module stream_driver
  import stream_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned DW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          launch,
  input  logic [7:0]    cfg_count,
  input  logic          cfg_gap,
  input  logic [DW-1:0] exp_value,
  input  logic          rec_valid,
  output logic          rec_ready,
  input  logic [DW-1:0] rec_a,
  input  logic [DW-1:0] rec_b,
  input  instr_t        rec_instr,
  output logic          start,
  output logic [7:0]    count,
  output logic          valid,
  output logic [DW-1:0] data_A,
  output logic [DW-1:0] data_B,
  output instr_t        instruction,
  input  logic          finish,
  input  logic [DW-1:0] third_largest,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [DW-1:0] result,
  output logic [7:0]    err_cnt,
  output logic          timeout,
  output logic          proto_err
);

  state_t        state, state_n;
  logic          gap_q;
  logic [DW-1:0] exp_q;
  logic          finish_q;
  logic [7:0]    beats;
  logic          last;
  logic          wd_expired;
  logic          xfer;
  logic          accept_finish;
  logic          to_hit;
  logic          proto_hit;
  logic          mismatch_hit;

  assign xfer          = (state == SEND) && rec_valid;
  // A finish that continues from the previous cycle is a protocol error, never a response
  assign accept_finish = (state == WAIT) && finish && !finish_q;
  assign to_hit        = (state == WAIT) && wd_expired && !accept_finish;
  assign proto_hit     = finish && (finish_q || (state == START) || (state == SEND) || (state == GAP));
  assign mismatch_hit  = accept_finish && (third_largest != exp_q);

  drv_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == IDLE) && launch),
    .load_val  (cfg_count),
    .dec       (xfer),
    .beats     (beats),
    .last      (last),
    .wd_run    (state == WAIT),
    .wd_expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    start       = 1'b0;
    count       = '0;
    rec_ready   = 1'b0;
    valid       = 1'b0;
    data_A      = '0;
    data_B      = '0;
    instruction = '0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_n = START;
      end
      START: begin
        start   = 1'b1;
        count   = beats;
        state_n = (beats != '0) ? SEND : WAIT;
      end
      SEND: begin
        rec_ready = 1'b1;
        if (rec_valid) begin
          valid       = 1'b1;
          data_A      = rec_a;
          data_B      = rec_b;
          instruction = rec_instr;
          if (gap_q)     state_n = GAP;
          else if (last) state_n = WAIT;
        end
      end
      GAP: begin
        state_n = (beats == '0) ? WAIT : SEND;
      end
      WAIT: begin
        if (accept_finish || to_hit) state_n = CHECK;
      end
      CHECK: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // result/pass are registered on the finish edge so they are already valid during CHECK
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= 1'b0;
      exp_q     <= '0;
      finish_q  <= 1'b0;
      pass      <= 1'b0;
      result    <= '0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      finish_q <= finish;
      if ((state == IDLE) && launch) begin
        gap_q <= cfg_gap;
        exp_q <= exp_value;
      end
      if (accept_finish) begin
        result <= third_largest;
        pass   <= (third_largest == exp_q);
      end
      if (to_hit) begin
        pass    <= 1'b0;
        timeout <= 1'b1;
      end
      if (proto_hit) proto_err <= 1'b1;
      err_cnt <= sat_inc(sat_inc(err_cnt, mismatch_hit || to_hit), proto_hit);
    end
  end

endmodule
